// File: rtl/burst_read_stream_if.sv
// Control, Avalon-MM read master and output stream signals of burst_read_stream.
// The master modport is the block's side; slave is the memory/consumer side.
interface burst_read_stream_if #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int LENGTH_WIDTH      = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 4
);
    logic                         ctrl_start;
    logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress;
    logic [LENGTH_WIDTH-1:0]      ctrl_length;
    logic                         ctrl_busy;
    logic                         ctrl_done;
    logic [ADDRESS_WIDTH-1:0]     master_address;
    logic                         master_read;
    logic [BURST_WIDTH-1:0]       master_burstcount;
    logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
    logic                         master_waitrequest;
    logic                         master_readdatavalid;
    logic [DATA_WIDTH-1:0]        master_readdata;
    logic [DATA_WIDTH-1:0]        user_data;
    logic                         user_valid;
    logic                         user_ready;

    modport master (
        input  ctrl_start, ctrl_baseaddress, ctrl_length,
        output ctrl_busy, ctrl_done,
        output master_address, master_read, master_burstcount, master_byteenable,
        input  master_waitrequest, master_readdatavalid, master_readdata,
        output user_data, user_valid,
        input  user_ready
    );

    modport slave (
        output ctrl_start, ctrl_baseaddress, ctrl_length,
        input  ctrl_busy, ctrl_done,
        input  master_address, master_read, master_burstcount, master_byteenable,
        output master_waitrequest, master_readdatavalid, master_readdata,
        input  user_data, user_valid,
        output user_ready
    );
endinterface

// File: rtl/burst_read_stream.sv
// Multi-burst Avalon-MM read master feeding a FIFO-backed valid/ready stream; read issues 1 cycle after start.
// Bursts are only requested when FIFO space covers every outstanding beat, so user_ready backpressure throttles the bus.
module burst_read_stream #(
    parameter int ADDRESS_WIDTH          = 32,
    parameter int LENGTH_WIDTH           = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int BYTE_ENABLE_WIDTH      = 4,
    parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
    parameter int BURST_COUNT            = 8,
    parameter int BURST_WIDTH            = 4,
    parameter int FIFO_DEPTH             = 32,
    parameter int FIFO_DEPTH_LOG2        = 5
) (
    input logic clk,
    input logic reset_n,
    burst_read_stream_if.master bus
);
    localparam int PW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [LENGTH_WIDTH-1:0]    BURST_MAX  = LENGTH_WIDTH'(BURST_COUNT);
    localparam logic [PW-1:0]              DEPTH      = PW'(FIFO_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0]   ALIGN_MASK = ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH - 1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state;
    logic [ADDRESS_WIDTH-1:0]   addr;
    logic [LENGTH_WIDTH-1:0]    remaining;
    logic [PW-1:0]              pending;
    logic [PW-1:0]              used;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];

    logic [LENGTH_WIDTH-1:0]    burst;
    logic [LENGTH_WIDTH-1:0]    start_burst;
    logic [LENGTH_WIDTH-1:0]    remaining_nxt;
    logic [PW-1:0]              pending_nxt;
    logic [PW-1:0]              used_nxt;
    logic [PW-1:0]              free;
    logic                       accept;
    logic                       push;
    logic                       pop;

    always_comb begin
        burst         = (remaining < BURST_MAX) ? remaining : BURST_MAX;
        start_burst   = (bus.ctrl_length < BURST_MAX) ? bus.ctrl_length : BURST_MAX;
        accept        = bus.master_read & ~bus.master_waitrequest;
        // Beats with nothing outstanding are leftovers of an abandoned transfer.
        push          = bus.master_readdatavalid & (pending != '0);
        pop           = bus.user_valid & bus.user_ready;
        remaining_nxt = remaining - (accept ? burst : '0);
        pending_nxt   = pending + (accept ? PW'(burst) : '0) - PW'(push);
        used_nxt      = used + PW'(push) - PW'(pop);
        free          = DEPTH - used - pending;
    end

    assign bus.master_byteenable = '1;
    assign bus.user_valid        = (used != '0);
    assign bus.user_data         = bus.user_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.master_readdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            addr                  <= '0;
            remaining             <= '0;
            pending               <= '0;
            used                  <= '0;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            bus.ctrl_busy         <= 1'b0;
            bus.ctrl_done         <= 1'b0;
            bus.master_read       <= 1'b0;
            bus.master_address    <= '0;
            bus.master_burstcount <= '0;
        end else begin
            bus.ctrl_done <= 1'b0;
            pending       <= pending_nxt;
            used          <= used_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case (state)
                IDLE: begin
                    // FIFO is empty and nothing is pending here, so the first burst always fits.
                    if (bus.ctrl_start && bus.ctrl_length != '0) begin
                        addr                  <= bus.ctrl_baseaddress & ~ALIGN_MASK;
                        remaining             <= bus.ctrl_length;
                        bus.master_address    <= bus.ctrl_baseaddress & ~ALIGN_MASK;
                        bus.master_burstcount <= BURST_WIDTH'(start_burst);
                        bus.master_read       <= 1'b1;
                        bus.ctrl_busy         <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        bus.master_read <= 1'b0;
                        addr            <= addr + (ADDRESS_WIDTH'(burst) << BYTE_ENABLE_WIDTH_LOG2);
                        remaining       <= remaining_nxt;
                        if (remaining_nxt == '0) state <= DRAIN;
                    end else if (!bus.master_read && free >= PW'(burst)) begin
                        bus.master_read       <= 1'b1;
                        bus.master_address    <= addr;
                        bus.master_burstcount <= BURST_WIDTH'(burst);
                    end
                end
                DRAIN: begin
                    if (pending_nxt == '0 && used_nxt == '0) begin
                        bus.ctrl_done <= 1'b1;
                        bus.ctrl_busy <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_read_stream.sv
// Randomized bench for burst_read_stream: memory slave, queue-based reference model, per-cycle compare at negedge.
module tb_burst_read_stream;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    burst_read_stream_if #(.ADDRESS_WIDTH(32), .LENGTH_WIDTH(32), .DATA_WIDTH(32),
                           .BYTE_ENABLE_WIDTH(4), .BURST_WIDTH(4)) bus ();

    burst_read_stream #(
        .ADDRESS_WIDTH(32), .LENGTH_WIDTH(32), .DATA_WIDTH(32), .BYTE_ENABLE_WIDTH(4),
        .BYTE_ENABLE_WIDTH_LOG2(2), .BURST_COUNT(8), .BURST_WIDTH(4),
        .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG2(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // model state (post-edge view)
    logic [31:0] exp_ba[$];
    int          exp_bc[$];
    logic [31:0] exp_words[$];
    logic [31:0] beat_q[$];
    int          outstanding = 0;
    int          occ = 0;
    bit          busy_m = 0;
    bit          done_exp = 0;
    bit          start_lat = 0;
    bit          prev_acc = 0;
    bit          held = 0;
    logic [31:0] held_addr;
    logic [3:0]  held_cnt;
    bit          mon_en = 0;

    // per-test logs
    logic [31:0] acc_addr [16];
    int          acc_cnt  [16];
    int          acc_n = 0;
    int          popped = 0;
    logic [31:0] first_word;
    int          hold_cycles = 0;
    int          done_count = 0;
    int          dut_done_cnt = 0;

    // slave/consumer behaviour
    int wait_mode = 0;
    int ready_mode = 1;
    int rdv_mode = 0;
    bit slave_hold = 0;
    bit stall_used = 0;
    int stall_left = 0;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return 32'h88990011 + ((a - 32'h38000000) >> 2);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] a;
        logic [31:0] base_al;
        int c;
        int outs_pre;
        int len;
        bit pop_now;
        if (mon_en && reset_n) begin
            chk("busy", bus.ctrl_busy, busy_m);
            chk("done", bus.ctrl_done, done_exp);
            chk("byteenable", bus.master_byteenable, 4'hF);
            chk("user_valid", bus.user_valid, occ != 0);
            if (occ != 0) chk("user_data", bus.user_data, exp_words[0]);
            if (start_lat) chk("start_latency", bus.master_read, 1);
            if (prev_acc) chk("req_spacing", bus.master_read, 0);
            if (held) begin
                chk("hold_read", bus.master_read, 1);
                chk("hold_addr", bus.master_address, held_addr);
                chk("hold_cnt", bus.master_burstcount, held_cnt);
            end else if (bus.master_read) begin
                if (exp_ba.size() == 0) chk("extra_burst", bus.master_read, 0);
                else begin
                    chk("burst_addr", bus.master_address, exp_ba[0]);
                    chk("burst_cnt", bus.master_burstcount, exp_bc[0]);
                    chk("credit", occ + outstanding + int'(bus.master_burstcount) <= DEPTH, 1);
                end
            end
            if (bus.ctrl_done) dut_done_cnt++;

            // apply what happens at the coming rising edge
            done_exp  = 0;
            start_lat = 0;
            outs_pre  = outstanding;
            if (bus.master_read && !bus.master_waitrequest) begin
                a = bus.master_address;
                c = int'(bus.master_burstcount);
                if (acc_n < 16) begin acc_addr[acc_n] = a; acc_cnt[acc_n] = c; end
                acc_n++;
                if (exp_ba.size() > 0) begin void'(exp_ba.pop_front()); void'(exp_bc.pop_front()); end
                outstanding += c;
                for (int j = 0; j < c; j++) beat_q.push_back(fdata(a + 32'(4 * j)));
                held = 0;
                prev_acc = 1;
            end else begin
                prev_acc = 0;
                held = bus.master_read;
                held_addr = bus.master_address;
                held_cnt = bus.master_burstcount;
                if (bus.master_read) hold_cycles++;
            end
            pop_now = (occ != 0) && bus.user_ready;
            if (pop_now) begin
                if (popped == 0) first_word = exp_words[0];
                void'(exp_words.pop_front());
                popped++;
                occ--;
            end
            if (bus.master_readdatavalid && outs_pre > 0) begin
                outstanding--;
                occ++;
            end
            if (bus.ctrl_start && !busy_m && bus.ctrl_length != 0) begin
                base_al = bus.ctrl_baseaddress & 32'hFFFF_FFFC;
                len = int'(bus.ctrl_length);
                for (int off = 0; off < len; off += 8) begin
                    exp_ba.push_back(base_al + 32'(4 * off));
                    exp_bc.push_back((len - off) < 8 ? (len - off) : 8);
                end
                for (int i = 0; i < len; i++) exp_words.push_back(fdata(base_al + 32'(4 * i)));
                busy_m = 1;
                start_lat = 1;
            end else if (busy_m && exp_ba.size() == 0 && outstanding == 0 && occ == 0) begin
                done_exp = 1;
                busy_m = 0;
                done_count++;
            end
        end
    end

    task automatic slave_loop();
        bit w;
        forever begin
            @(posedge clk);
            #1;
            if (slave_hold) begin
                bus.master_waitrequest = 1'b0;
                bus.master_readdatavalid = 1'b0;
            end else begin
                if (wait_mode == 0) w = 0;
                else if (wait_mode == 1) w = ($urandom_range(0, 2) == 0);
                else begin
                    if (!stall_used && bus.master_read && acc_n == 1) begin
                        stall_used = 1;
                        stall_left = 3;
                    end
                    if (stall_left > 0) begin w = 1; stall_left--; end
                    else w = 0;
                end
                bus.master_waitrequest = w;
                if (beat_q.size() > 0 && (rdv_mode == 0 || $urandom_range(0, 1) == 1)) begin
                    bus.master_readdatavalid = 1'b1;
                    bus.master_readdata = beat_q.pop_front();
                end else begin
                    bus.master_readdatavalid = 1'b0;
                end
            end
            bus.user_ready = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len);
        @(posedge clk);
        #1;
        bus.ctrl_start = 1'b1;
        bus.ctrl_baseaddress = base;
        bus.ctrl_length = len;
        @(posedge clk);
        #1;
        bus.ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        int d0 = done_count;
        while (done_count == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, done_count != d0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc_n = 0;
        popped = 0;
        hold_cycles = 0;
        dut_done_cnt = 0;
        first_word = '0;
    endtask

    task automatic clear_model();
        exp_ba.delete();
        exp_bc.delete();
        exp_words.delete();
        outstanding = 0;
        occ = 0;
        busy_m = 0;
        done_exp = 0;
        start_lat = 0;
        prev_acc = 0;
        held = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, bus.ctrl_busy, 0);
        chk({tag, "_done"}, bus.ctrl_done, 0);
        chk({tag, "_read"}, bus.master_read, 0);
        chk({tag, "_addr"}, bus.master_address, 0);
        chk({tag, "_cnt"}, bus.master_burstcount, 0);
        chk({tag, "_be"}, bus.master_byteenable, 4'hF);
        chk({tag, "_valid"}, bus.user_valid, 0);
        chk({tag, "_data"}, bus.user_data, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        reset_n = 1'b0;
        bus.ctrl_start = 1'b0;
        bus.ctrl_baseaddress = '0;
        bus.ctrl_length = '0;
        bus.master_waitrequest = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        bus.user_ready = 1'b0;
        fork slave_loop(); join_none
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        #1;
        reset_n = 1'b1;
        mon_en = 1;
        repeat (2) @(posedge clk);

        // single burst
        wait_mode = 0; ready_mode = 1; rdv_mode = 0;
        clear_logs();
        start(32'h38000000, 8);
        wait_done("t1_done", 200);
        chk("t1_bursts", acc_n, 1);
        chk("t1_addr", acc_addr[0], 32'h38000000);
        chk("t1_cnt", acc_cnt[0], 8);
        chk("t1_words", popped, 8);
        chk("t1_first", first_word, 32'h88990011);
        chk("t1_pulses", dut_done_cnt, 1);

        // multi-burst split
        clear_logs();
        start(32'h38000000, 20);
        wait_done("t2_done", 300);
        chk("t2_bursts", acc_n, 3);
        chk("t2_addr0", acc_addr[0], 32'h38000000);
        chk("t2_addr1", acc_addr[1], 32'h38000020);
        chk("t2_addr2", acc_addr[2], 32'h38000040);
        chk("t2_cnt0", acc_cnt[0], 8);
        chk("t2_cnt1", acc_cnt[1], 8);
        chk("t2_cnt2", acc_cnt[2], 4);
        chk("t2_words", popped, 20);

        // waitrequest stall on second burst
        clear_logs();
        wait_mode = 2; stall_used = 0; stall_left = 0;
        start(32'h38000000, 20);
        wait_done("t3_done", 300);
        chk("t3_bursts", acc_n, 3);
        chk("t3_stall_cycles", hold_cycles, 3);
        chk("t3_words", popped, 20);
        wait_mode = 0;

        // backpressure
        clear_logs();
        ready_mode = 0;
        start(32'h38000000, 64);
        repeat (100) @(posedge clk);
        #1;
        chk("t4_bursts_blocked", acc_n, 4);
        chk("t4_read_low", bus.master_read, 0);
        chk("t4_fifo_full_valid", bus.user_valid, 1);
        ready_mode = 1;
        wait_done("t4_done", 2000);
        chk("t4_bursts", acc_n, 8);
        chk("t4_words", popped, 64);

        // reset mid-transfer
        clear_logs();
        ready_mode = 2; rdv_mode = 1;
        start(32'h38000000, 20);
        n = 0;
        while (!(popped >= 1 && beat_q.size() > 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("t5_reached_mid", n < 300, 1);
        mon_en = 0;
        slave_hold = 1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero("t5_rst");
        clear_model();
        clear_logs();
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        mon_en = 1;
        slave_hold = 0;
        n = 0;
        while (beat_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t5_late_dropped_valid", bus.user_valid, 0);
        chk("t5_late_dropped_busy", bus.ctrl_busy, 0);
        ready_mode = 1; rdv_mode = 0;
        clear_logs();
        start(32'h38000000, 8);
        wait_done("t5_restart_done", 200);
        chk("t5_restart_words", popped, 8);
        chk("t5_restart_pulses", dut_done_cnt, 1);

        // ignored starts and alignment
        clear_logs();
        start(32'h38000000, 8);
        start(32'h50000000, 5);
        wait_done("t6_done", 200);
        chk("t6_busy_start_bursts", acc_n, 1);
        chk("t6_busy_start_words", popped, 8);
        start(32'h12345678, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_zero_len_busy", bus.ctrl_busy, 0);
        chk("t6_zero_len_bursts", acc_n, 1);
        chk("t6_zero_len_pulses", dut_done_cnt, 1);
        clear_logs();
        start(32'h38000003, 3);
        wait_done("t6_align_done", 200);
        chk("t6_align_addr", acc_addr[0], 32'h38000000);
        chk("t6_align_cnt", acc_cnt[0], 3);
        chk("t6_align_first", first_word, 32'h88990011);

        // randomized transfers
        for (int t = 0; t < 8; t++) begin
            wait_mode = $urandom_range(0, 1);
            ready_mode = $urandom_range(1, 2);
            rdv_mode = $urandom_range(0, 1);
            len = $urandom_range(1, 70);
            clear_logs();
            start($urandom, 32'(len));
            wait_done("rand_done", 4000);
            chk("rand_words", popped, len);
            chk("rand_bursts", acc_n, (len + 7) / 8);
            chk("rand_model_empty", exp_words.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
